// File: rtl/rsa_exp_sched_if.sv
// Requester, response, config and engine-side signals of the modexp job scheduler.
// slave is the scheduler's view; master is the requester/engine side.
interface rsa_exp_sched_if #(
   parameter int IN_BIT  = 3,
   parameter int MOD_BIT = 5,
   parameter int EXP_BIT = 3
);
   logic               req0_valid, req1_valid;
   logic               req0_ready, req1_ready;
   logic [IN_BIT-1:0]  req0_base, req1_base;
   logic [EXP_BIT-1:0] req0_exp, req1_exp;
   logic               cfg_we;
   logic [MOD_BIT-1:0] cfg_n, cfg_n_inv;
   logic               rsp0_valid, rsp1_valid;
   logic               rsp0_ready, rsp1_ready;
   logic [MOD_BIT:0]   rsp0_result, rsp1_result;
   logic               rsp0_err, rsp1_err;
   logic               busy;
   logic               eng_rst_n;
   logic [IN_BIT-1:0]  eng_in;
   logic [EXP_BIT-1:0] eng_exp;
   logic [MOD_BIT-1:0] eng_n, eng_n_inv;
   logic               eng_done;
   logic [MOD_BIT:0]   eng_out;

   modport slave (
      input  req0_valid, req1_valid, req0_base, req1_base, req0_exp, req1_exp,
      input  cfg_we, cfg_n, cfg_n_inv, rsp0_ready, rsp1_ready, eng_done, eng_out,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
      output rsp0_err, rsp1_err, busy, eng_rst_n, eng_in, eng_exp, eng_n, eng_n_inv
   );

   modport master (
      output req0_valid, req1_valid, req0_base, req1_base, req0_exp, req1_exp,
      output cfg_we, cfg_n, cfg_n_inv, rsp0_ready, rsp1_ready, eng_done, eng_out,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
      input  rsp0_err, rsp1_err, busy, eng_rst_n, eng_in, eng_exp, eng_n, eng_n_inv
   );
endinterface

// File: rtl/rsa_exp_sched.sv
// Round-robin job scheduler for the shared Montgomery modexp engine: grants one of two
// requesters, sequences the engine through its reset line, and returns result or error.
module rsa_exp_sched #(
   parameter int IN_BIT  = 3,
   parameter int MOD_BIT = 5,
   parameter int EXP_BIT = 3,
   parameter int TIMEOUT = 255
) (
   input logic             clk,
   input logic             rst,
   rsa_exp_sched_if.slave  bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

   state_t             state, state_nx;
   logic               last_grant, owner;
   logic [IN_BIT-1:0]  base_q;
   logic [EXP_BIT-1:0] exp_q;
   logic [MOD_BIT-1:0] n_q, n_inv_q;
   logic [MOD_BIT:0]   result_q;
   logic               err_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               grant_vld, grant, accept, timeout_hit, rsp_take;

   always_comb begin
      grant_vld = 1'b0;
      grant     = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         grant_vld = 1'b1;
         grant     = ~last_grant;
      end else if (bus.req0_valid) begin
         grant_vld = 1'b1;
      end else if (bus.req1_valid) begin
         grant_vld = 1'b1;
         grant     = 1'b1;
      end
   end

   // Gating with rst keeps ready low while the async reset holds state at IDLE.
   assign accept      = rst && (state == IDLE) && !bus.cfg_we && grant_vld;
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
   assign rsp_take    = owner ? bus.rsp1_ready : bus.rsp0_ready;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = n_q[0] ? LAUNCH : RESP;
         LAUNCH:  state_nx = RUN;
         RUN:     if (bus.eng_done || timeout_hit) state_nx = RESP;
         RESP:    if (rsp_take) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         base_q     <= '0;
         exp_q      <= '0;
         n_q        <= '0;
         n_inv_q    <= '0;
         result_q   <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (bus.cfg_we) begin
                  n_q     <= bus.cfg_n;
                  n_inv_q <= bus.cfg_n_inv;
               end else if (accept) begin
                  base_q     <= grant ? bus.req1_base : bus.req0_base;
                  exp_q      <= grant ? bus.req1_exp  : bus.req0_exp;
                  owner      <= grant;
                  last_grant <= grant;
                  // An even modulus cannot be Montgomery-reduced; fail the job without the engine.
                  if (!n_q[0]) begin
                     result_q <= '0;
                     err_q    <= 1'b1;
                  end
               end
            end
            LAUNCH: cnt_q <= '0;
            RUN: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (bus.eng_done) begin
                  result_q <= bus.eng_out;
                  err_q    <= 1'b0;
               end else if (timeout_hit) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req0_ready  = accept && !grant;
   assign bus.req1_ready  = accept && grant;
   assign bus.rsp0_valid  = (state == RESP) && !owner;
   assign bus.rsp1_valid  = (state == RESP) && owner;
   assign bus.rsp0_result = result_q;
   assign bus.rsp1_result = result_q;
   assign bus.rsp0_err    = err_q;
   assign bus.rsp1_err    = err_q;
   assign bus.busy        = (state != IDLE);
   assign bus.eng_rst_n   = (state == RUN);
   assign bus.eng_in      = base_q;
   assign bus.eng_exp     = exp_q;
   assign bus.eng_n       = n_q;
   assign bus.eng_n_inv   = n_inv_q;
endmodule

// File: doc/rsa_exp_sched.md
# rsa_exp_sched

Job scheduler and sequencer for the shared Montgomery modular-exponentiation engine. It arbitrates two requesters round-robin and latches each granted job's base and exponent. It launches the engine by releasing the engine's active-low reset, waits for completion or a watchdog timeout, and returns the result to the owning requester over a valid/ready channel. Modulus and Montgomery constant are shared configuration registers owned by this block.

## Interface
- IN_BIT, 3, base width
- MOD_BIT, 5, modulus width; result width is MOD_BIT+1
- EXP_BIT, 3, exponent width
- TIMEOUT, 255, max RUN cycles before abort; counter width $clog2(TIMEOUT+1)

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- req0_valid, req1_valid  in  1  job request
- req0_ready, req1_ready  out  1  job accepted this cycle
- req0_base, req1_base  in  IN_BIT  base operand
- req0_exp, req1_exp  in  EXP_BIT  exponent
- cfg_we  in  1  write modulus config
- cfg_n  in  MOD_BIT  modulus (odd, MSB set)
- cfg_n_inv  in  MOD_BIT  Montgomery constant -n^-1 mod 2^MOD_BIT
- rsp0_valid, rsp1_valid  out  1  result available
- rsp0_ready, rsp1_ready  in  1  result consumed
- rsp0_result, rsp1_result  out  MOD_BIT+1  shared result register
- rsp0_err, rsp1_err  out  1  job failed (bad modulus or timeout)
- busy  out  1  state != IDLE
- eng_rst_n  out  1  engine reset; low holds engine idle
- eng_in  out  IN_BIT  latched base
- eng_exp  out  EXP_BIT  latched exponent
- eng_n, eng_n_inv  out  MOD_BIT  config registers
- eng_done  in  1  engine finished
- eng_out  in  MOD_BIT+1  engine result

## Operation
- States: IDLE, LAUNCH, RUN, RESP. Encoding is registered; next-state logic is combinational.
- Reset values:
  - state=IDLE, last_grant=1, so req0 wins the first tie.
  - cfg n / n_inv = 0; operand, result and err registers = 0; timeout counter = 0.
  - While rst is low, all req_ready and rsp_valid are forced to 0 and eng_rst_n=0.
- IDLE:
  - If cfg_we=1, write cfg_n and cfg_n_inv. No request is accepted that cycle; config has priority.
  - Otherwise grant is computed as follows: if both requesters are valid, grant goes to !last_grant; if one is valid, grant goes to it.
  - req{g}_ready=1 combinationally for the granted requester only. At the handshake, latch base and exponent, set owner=g and last_grant=g.
  - If the stored eng_n[0]=0 at accept, the engine is skipped: result=0, err=1, next state RESP. Otherwise next state is LAUNCH.
- cfg_we outside IDLE is ignored. The config registers do not change mid-job.
- LAUNCH: lasts 1 cycle with eng_rst_n=0 and operands stable. Clear the timeout counter, then go to RUN.
- RUN:
  - eng_rst_n = 1. This is the only state in which it is 1; it is decoded from the state register.
  - Counter increments each cycle.
  - eng_done=1: capture eng_out into result, err=0, go to RESP.
  - Else if counter == TIMEOUT-1: result=0, err=1, go to RESP.
  - If eng_done and the timeout coincide, done wins.
- RESP:
  - rsp{owner}_valid=1 with result and err held stable. The other rsp_valid stays 0.
  - On rsp{owner}_ready=1, go to IDLE. While in RESP, eng_rst_n=0 clears the engine's sticky done.
- eng_done is ignored in every state except RUN.
- rst asserted mid-job: the job is dropped with no response; all registers return to their reset values.

## Timing
- Handshake in IDLE at cycle T.
  - Cycle T+1 is LAUNCH; eng_rst_n rises entering T+2.
  - If eng_done is first high at cycle T+2+k, rsp_valid is high from T+3+k.
- Bad-modulus job: rsp_valid is high at T+1.
- Timeout job: rsp_valid is high at T+2+TIMEOUT.
- Minimum job-to-job spacing: rsp handshake at cycle R makes the scheduler IDLE at R+1, where the next request can be accepted.
- req_valid and operands must stay stable until ready; there is no queueing and at most one job is in flight.

## Test plan
- Setup: n=23, n_inv=25 written in IDLE. Engine model asserts done 20 cycles after eng_rst_n rises.
  - req0 base=5, exp=6 -> req0_ready same cycle; eng_rst_n low 1 cycle then high; rsp0_valid with result=8, err=0 at accept+23.
- Both requesters valid after reset: req0 (exp=6) and req1 (exp=3) -> req0 served first with result 8; req1 served next with result 10; a repeated tie alternates grant.
- Engine model never asserts done, TIMEOUT=255 -> rsp_valid at accept+257 with result=0, err=1; eng_rst_n returns to 0.
- cfg_we with n=22 then a request -> no LAUNCH; rsp_valid next cycle with err=1, result=0. cfg_we during RUN -> eng_n remains 23.
- rsp0_ready held low 10 cycles -> result stable, busy=1, req1_ready stays 0. rst pulsed low during RUN -> rsp_valid=0, eng_rst_n=0, state IDLE, req0 wins the next tie.
